// File: rtl/floating_add_cmp_conv.sv
// floating_add_cmp_conv: binary32 add/sub, signed int32->float and compare, live while enabled, held otherwise.
// Define FLOAT_RNE_EN for round-to-nearest-even; the default build rounds toward zero.
module floating_add_cmp_conv (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic [1:0]  cmp,
  output logic [31:0] debug
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        flush;
    logic        inexact;
  } pack_t;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 32; i++)
      if (v[i]) n = 5'(31 - i);
    return n;
  endfunction

  // m carries 1.frac in [26:3] followed by guard, round and sticky bits
  function automatic pack_t roundPack(input logic sign, input logic signed [10:0] exp,
                                      input logic [26:0] m);
    pack_t              p;
    logic               inc;
    logic [24:0]        rm;
    logic signed [10:0] e;
    p         = '0;
    p.inexact = |m[2:0];
`ifdef FLOAT_RNE_EN
    inc = m[2] & (m[1] | m[0] | m[3]);
`else
    inc = 1'b0;
`endif
    rm = {1'b0, m[26:3]} + {24'd0, inc};
    e  = exp;
    if (rm[24]) begin
      rm = '0;
      e  = e + 11'sd1;
    end
    if (e <= 11'sd0) begin
      p.res     = 32'h0;
      p.flush   = 1'b1;
      p.inexact = 1'b1;
    end else if (e >= 11'sd255) begin
      p.res     = {sign, 8'hFF, 23'd0};
      p.ovf     = 1'b1;
      p.inexact = 1'b1;
    end else begin
      p.res = {sign, e[7:0], rm[22:0]};
    end
    return p;
  endfunction

  logic        aSign, bSign, bSignEff, aNan, bNan, aInf, bInf;
  logic [7:0]  aExp, bExp;
  logic [22:0] aFrac, bFrac;
  logic [30:0] aMag, bMag;

  // Denormal operands collapse to signed zero by clearing their fraction.
  assign aSign    = a[31];
  assign bSign    = b[31];
  assign bSignEff = b[31] ^ op[0];
  assign aExp     = a[30:23];
  assign bExp     = b[30:23];
  assign aFrac    = (aExp == 8'd0) ? 23'd0 : a[22:0];
  assign bFrac    = (bExp == 8'd0) ? 23'd0 : b[22:0];
  assign aNan     = (aExp == 8'hFF) && (a[22:0] != 23'd0);
  assign bNan     = (bExp == 8'hFF) && (b[22:0] != 23'd0);
  assign aInf     = (aExp == 8'hFF) && (a[22:0] == 23'd0);
  assign bInf     = (bExp == 8'hFF) && (b[22:0] == 23'd0);
  assign aMag     = {aExp, aFrac};
  assign bMag     = {bExp, bFrac};

  logic               swap, effSub, bigSign, smallSign, addInvalid;
  logic [7:0]         bigExp, smallExp, expDiff;
  logic [23:0]        bigMan, smallMan;
  logic [26:0]        smallExt, aligned, stickyMask, normM;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic signed [10:0] normExp;
  pack_t              addPack;

  always_comb begin
    swap       = bMag > aMag;
    bigSign    = swap ? bSignEff : aSign;
    smallSign  = swap ? aSign : bSignEff;
    bigExp     = swap ? bExp : aExp;
    smallExp   = swap ? aExp : bExp;
    bigMan     = swap ? {bExp != 8'd0, bFrac} : {aExp != 8'd0, aFrac};
    smallMan   = swap ? {aExp != 8'd0, aFrac} : {bExp != 8'd0, bFrac};
    effSub     = bigSign ^ smallSign;
    expDiff    = bigExp - smallExp;
    smallExt   = {smallMan, 3'b000};
    stickyMask = '0;
    if (expDiff >= 8'd27) begin
      aligned = {26'd0, |smallMan};
    end else begin
      stickyMask = (27'd1 << expDiff) - 27'd1;
      aligned    = (smallExt >> expDiff) | {26'd0, |(smallExt & stickyMask)};
    end
    sum = effSub ? ({1'b0, bigMan, 3'b000} - {1'b0, aligned})
                 : ({1'b0, bigMan, 3'b000} + {1'b0, aligned});
    lz  = lzc27(sum[26:0]);
    if (sum[27]) begin
      normM   = {sum[27:2], |sum[1:0]};
      normExp = $signed({3'b000, bigExp}) + 11'sd1;
    end else begin
      normM   = sum[26:0] << lz;
      normExp = $signed({3'b000, bigExp}) - $signed({6'd0, lz});
    end
    addPack    = roundPack(bigSign, normExp, normM);
    addInvalid = 1'b0;
    if (aNan || bNan || (aInf && bInf && (aSign != bSignEff))) begin
      addPack     = '0;
      addPack.res = QNAN;
      addInvalid  = 1'b1;
    end else if (aInf) begin
      addPack     = '0;
      addPack.res = {aSign, 8'hFF, 23'd0};
    end else if (bInf) begin
      addPack     = '0;
      addPack.res = {bSignEff, 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      // Only two negative zeros keep the sign; every other cancellation gives +0.
      addPack     = '0;
      addPack.res = {aSign & bSignEff, 31'd0};
    end
  end

  logic [31:0] convMag, convN;
  logic [4:0]  convLz;
  pack_t       convPack;

  always_comb begin
    convMag  = a[31] ? (~a + 32'd1) : a;
    convLz   = lzc32(convMag);
    convN    = convMag << convLz;
    convPack = roundPack(a[31], 11'sd158 - $signed({6'd0, convLz}),
                         {convN[31:8], convN[7], convN[6], |convN[5:0]});
    if (convMag == 32'd0) convPack = '0;
  end

  logic [1:0] cmpVal;
  logic       cmpInvalid;

  always_comb begin
    cmpInvalid = aNan | bNan;
    if (cmpInvalid)                         cmpVal = 2'b10;
    else if (aMag == 31'd0 && bMag == 31'd0) cmpVal = 2'b00;
    else if (aSign != bSign)                 cmpVal = aSign ? 2'b11 : 2'b01;
    else if (aMag == bMag)                   cmpVal = 2'b00;
    else if ((aMag > bMag) ^ aSign)          cmpVal = 2'b01;
    else                                     cmpVal = 2'b11;
  end

  logic [31:0] result_d, result_q, debug_d, debug_q;
  logic [1:0]  cmp_d, cmp_q;
  pack_t       sel;
  logic        selInv, zeroFlag;

  // Compare leaves result untouched and arithmetic ops leave cmp untouched.
  always_comb begin
    result_d = result_q;
    cmp_d    = cmp_q;
    sel      = '0;
    selInv   = 1'b0;
    zeroFlag = 1'b0;
    case (op)
      2'b10:   sel = convPack;
      2'b11:   sel = '0;
      default: begin
        sel    = addPack;
        selInv = addInvalid;
      end
    endcase
    if (op == 2'b11) begin
      cmp_d    = cmpVal;
      selInv   = cmpInvalid;
      zeroFlag = (cmpVal == 2'b00);
    end else begin
      result_d = sel.res;
      zeroFlag = (sel.res[30:0] == 31'd0);
    end
    debug_d = {op, 25'd0, selInv, sel.ovf, sel.flush, sel.inexact, zeroFlag};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
      cmp_q    <= '0;
      debug_q  <= '0;
    end else if (enable) begin
      result_q <= result_d;
      cmp_q    <= cmp_d;
      debug_q  <= debug_d;
    end
  end

  assign result = enable ? result_d : result_q;
  assign cmp    = enable ? cmp_d    : cmp_q;
  assign debug  = enable ? debug_d  : debug_q;

endmodule

// File: tb/tb_floating_add_cmp_conv.sv
// Self-checking bench for floating_add_cmp_conv: vector table plus hold/reset sequences, scoreboard-checked.
module tb_floating_add_cmp_conv;

   logic        clk, reset, enable;
   logic [1:0]  op;
   logic [31:0] a, b, result, debug;
   logic [1:0]  cmp;

   floating_add_cmp_conv dut (
      .clk(clk), .reset(reset), .enable(enable), .op(op), .a(a), .b(b),
      .result(result), .cmp(cmp), .debug(debug)
   );

   // Free-running 10ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [1:0]  cmpv;
      logic [4:0]  flags;
      logic [4:0]  fmask;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic [1:0]  cmpv;
      logic [31:0] dbg;
      logic [31:0] dmask;
   } exp_t;

   vec_t        vecs[$];
   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] modelResult = '0;
   logic [1:0]  modelCmp = '0;
   logic [31:0] modelDebug = '0;
   logic [31:0] modelMask = '1;

`ifdef FLOAT_RNE_EN
   localparam logic [31:0] CONV_TIE  = 32'h4B80_0002;
   localparam logic [31:0] CONV_MAX  = 32'h4F00_0000;
   localparam logic [31:0] ADD_TIEOD = 32'h3F80_0002;
`else
   localparam logic [31:0] CONV_TIE  = 32'h4B80_0001;
   localparam logic [31:0] CONV_MAX  = 32'h4EFF_FFFF;
   localparam logic [31:0] ADD_TIEOD = 32'h3F80_0001;
`endif

   // Flag order is {invalid, overflow, flushed, inexact, zero}; fmask drops flags a vector does not pin down
   task automatic addVec(input string n, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic [1:0] c, input logic [4:0] f, input logic [4:0] m);
      vec_t v;
      v.name = n; v.op = o; v.a = x; v.b = y; v.res = r; v.cmpv = c; v.flags = f; v.fmask = m;
      vecs.push_back(v);
   endtask

   task automatic checkEq(input string n, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", n, act, expv);
      end
   endtask

   // Drive one operation and queue what the outputs must show; enabled ops also become the held state
   task automatic applyStimulus(input logic en, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] r, input logic [1:0] c, input logic [4:0] f,
                                input logic [4:0] m, input string n);
      exp_t e;
      enable = en; op = o; a = x; b = y;
      e.name = n;
      if (en) begin
         e.res   = (o == 2'b11) ? modelResult : r;
         e.cmpv  = (o == 2'b11) ? c : modelCmp;
         e.dbg   = {o, 25'd0, f};
         e.dmask = {2'b11, 25'd0, m};
         modelResult = e.res; modelCmp = e.cmpv; modelDebug = e.dbg; modelMask = e.dmask;
      end else begin
         e.res = modelResult; e.cmpv = modelCmp; e.dbg = modelDebug; e.dmask = modelMask;
      end
      sb.push_back(e);
   endtask

   task automatic expectHeld(input string n);
      exp_t e;
      e.name = n; e.res = modelResult; e.cmpv = modelCmp; e.dbg = modelDebug; e.dmask = modelMask;
      sb.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      if (sb.size() == 0) begin
         checks++; failures++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries expected at least 1");
         return;
      end
      e = sb.pop_front();
      checkEq({e.name, "_result"}, result, e.res);
      checkEq({e.name, "_cmp"}, {30'd0, cmp}, {30'd0, e.cmpv});
      checkEq({e.name, "_debug"}, debug & e.dmask, e.dbg & e.dmask);
   endtask

   task automatic resetModel();
      modelResult = '0; modelCmp = '0; modelDebug = '0; modelMask = '1;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; op = 2'b00; a = '0; b = '0;

      addVec("add_1p2",      2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2'b00, 5'b00000, 5'h1F);
      addVec("sub_3m1",      2'b01, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 2'b00, 5'b00000, 5'h1F);
      addVec("sub_pi_pi",    2'b01, 32'h4049_0FDB, 32'h4049_0FDB, 32'h0000_0000, 2'b00, 5'b00001, 5'h1F);
      addVec("sub_1m2",      2'b01, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 2'b00, 5'b00000, 5'h1F);
      addVec("conv_tie",     2'b10, 32'h0100_0003, 32'h0,         CONV_TIE,      2'b00, 5'b00010, 5'h1F);
      addVec("conv_m1",      2'b10, 32'hFFFF_FFFF, 32'h0,         32'hBF80_0000, 2'b00, 5'b00000, 5'h1F);
      addVec("conv_zero",    2'b10, 32'h0000_0000, 32'h0,         32'h0000_0000, 2'b00, 5'b00001, 5'h1F);
      addVec("conv_minint",  2'b10, 32'h8000_0000, 32'h0,         32'hCF00_0000, 2'b00, 5'b00000, 5'h1F);
      addVec("conv_maxint",  2'b10, 32'h7FFF_FFFF, 32'h0,         CONV_MAX,      2'b00, 5'b00010, 5'h1F);
      addVec("conv_5",       2'b10, 32'h0000_0005, 32'h0,         32'h40A0_0000, 2'b00, 5'b00000, 5'h1F);
      addVec("inf_m_inf",    2'b00, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 2'b00, 5'b10000, 5'h1F);
      addVec("overflow",     2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 2'b00, 5'b01000, 5'b11101);
      addVec("negz_negz",    2'b00, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 2'b00, 5'b00001, 5'h1F);
      addVec("inf_p_1",      2'b00, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 2'b00, 5'b00000, 5'h1F);
      addVec("nan_p_1",      2'b00, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 2'b00, 5'b00000, 5'b01111);
      addVec("denorm_in",    2'b00, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 2'b00, 5'b00001, 5'b11011);
      addVec("underflow",    2'b01, 32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 2'b00, 5'b00101, 5'b11101);
      addVec("tie_even",     2'b00, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 2'b00, 5'b00010, 5'h1F);
      addVec("tie_odd",      2'b00, 32'h3F80_0001, 32'h3380_0000, ADD_TIEOD,     2'b00, 5'b00010, 5'h1F);
      addVec("cancel",       2'b00, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 2'b00, 5'b00001, 5'h1F);
      addVec("add_2m3",      2'b00, 32'h4000_0000, 32'hC040_0000, 32'hBF80_0000, 2'b00, 5'b00000, 5'h1F);
      addVec("cmp_lt",       2'b11, 32'h3F80_0000, 32'h4000_0000, 32'h0,         2'b11, 5'b00000, 5'h1F);
      addVec("cmp_zeros",    2'b11, 32'h8000_0000, 32'h0000_0000, 32'h0,         2'b00, 5'b00001, 5'h1F);
      addVec("cmp_nan",      2'b11, 32'h7FC0_0000, 32'h0000_0000, 32'h0,         2'b10, 5'b10000, 5'h1F);
      addVec("cmp_gt",       2'b11, 32'h4000_0000, 32'h3F80_0000, 32'h0,         2'b01, 5'b00000, 5'h1F);
      addVec("cmp_neg_gt",   2'b11, 32'hBF80_0000, 32'hC000_0000, 32'h0,         2'b01, 5'b00000, 5'h1F);
      addVec("cmp_ninf_lt",  2'b11, 32'hFF80_0000, 32'h3F80_0000, 32'h0,         2'b11, 5'b00000, 5'h1F);
      addVec("cmp_denorm",   2'b11, 32'h0000_0001, 32'h8000_0000, 32'h0,         2'b00, 5'b00001, 5'h1F);
      addVec("cmp_eq",       2'b11, 32'h3F80_0000, 32'h3F80_0000, 32'h0,         2'b00, 5'b00001, 5'h1F);

      #3;
      expectHeld("reset_state");
      checkOutput();
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cmpv,
                       vecs[i].flags, vecs[i].fmask, vecs[i].name);
         #2 checkOutput();
      end

      // Held value must survive operand changes once enable drops
      @(negedge clk);
      applyStimulus(1'b1, 2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2'b00, 5'b00000, 5'h1F, "hold_load");
      #2 checkOutput();
      @(negedge clk);
      applyStimulus(1'b0, 2'b01, 32'h4049_0FDB, 32'h3F80_0000, 32'h0, 2'b00, 5'b0, 5'h1F, "hold_en0");
      #2 checkOutput();

      // Asynchronous reset between edges clears the held outputs immediately
      #1 reset = 1'b0;
      resetModel();
      expectHeld("reset_pulse");
      #1 checkOutput();
      reset = 1'b1;

      // Live values still flow while reset is asserted with enable high
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b1, 2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 2'b00, 5'b00000, 5'h1F, "reset_live");
      #2 checkOutput();
      #1 reset = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, 2'b10, 32'h0000_0007, 32'h0, 32'h0, 2'b00, 5'b0, 5'h1F, "after_reset_held");
      #2 checkOutput();
      @(negedge clk);
      applyStimulus(1'b1, 2'b11, 32'h3F80_0000, 32'h4000_0000, 32'h0, 2'b11, 5'b00000, 5'h1F, "cmp_keeps_result");
      #2 checkOutput();

      @(negedge clk);
      enable = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
